// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU operation encodings driven by EX on the op bus
//   - FSM state type used by the mdu top
//   - helper to classify divide operations
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> MDU bundle.
//   master (EX side): drives flush, start, op, src_a, src_b;
//                     receives stall, busy and the HI/LO write port.
//   slave  (mdu):     the mirror image.
interface mdu_if #(
  parameter int WIDTH = 32
) ();

  logic             flush;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wb_hi;
  logic [WIDTH-1:0] wb_lo;

  modport master (
    output flush, start, op, src_a, src_b,
    input  stall, busy, we_hi, we_lo, wb_hi, wb_lo
  );

  modport slave (
    input  flush, start, op, src_a, src_b,
    output stall, busy, we_hi, we_lo, wb_hi, wb_lo
  );

endinterface

// File: rtl/mdu_div_core.sv
// div_core: iterative unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : load dividend/divisor and begin WIDTH iterations
//   abort      : drop the divide in flight (priority over start)
//   dividend   : unsigned dividend, sampled on start
//   divisor    : unsigned divisor, sampled on start
//   done       : this cycle's iteration is the last one
//   quotient   : quotient/remainder after this cycle's iteration; the final
//   remainder    results when done=1, so the parent can register them on the
//                same edge that completes the divide
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem_shift;
  logic             fits;

  // quo starts as the dividend and shifts left each step: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  // rem_shift needs one extra bit; when the divisor fits, the difference is
  // below the divisor and so fits back into WIDTH bits.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign fits      = rem_shift >= {1'b0, dvs};
  assign remainder = fits ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
  assign quotient  = {quo[WIDTH-2:0], fits};
  assign done      = running && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else if (abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
    end else if (running) begin
      rem <= remainder;
      quo <= quotient;
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit feeding the HI/LO register file.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mdu_if.slave
//     flush, start, op, src_a, src_b : op request from EX
//     stall : hold IF..EX (combinational)
//     busy  : divide in progress
//     we_hi/we_lo/wb_hi/wb_lo : registered single-cycle HI/LO write port
// Multiplies and moves write the cycle after issue; divides run WIDTH
// iterations in div_core and write the cycle after the last one.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  state_t             state;
  logic               we_hi_r;
  logic               we_lo_r;
  logic [WIDTH-1:0]   wb_hi_r;
  logic [WIDTH-1:0]   wb_lo_r;

  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   raw_a;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic               div_issue;
  logic               div_done;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // The low 2*WIDTH bits of the product of sign-extended operands are the
  // signed product; zero extension gives the unsigned one.
  assign prod_s = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a} *
                  {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
  assign prod_u = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};

  // Only signed DIV takes magnitudes; -0x80000000 wraps to itself, which is
  // the correct unsigned magnitude.
  assign a_neg   = (bus.op == OP_DIV) && bus.src_a[WIDTH-1];
  assign b_neg   = (bus.op == OP_DIV) && bus.src_b[WIDTH-1];
  assign dvd_abs = a_neg ? -bus.src_a : bus.src_a;
  assign dvs_abs = b_neg ? -bus.src_b : bus.src_b;

  assign div_issue = (state == IDLE) && bus.start && !bus.flush && is_div_op(bus.op);

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_issue),
    .abort     (bus.flush),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Divide by zero bypasses sign correction: all-ones quotient and the raw
  // dividend as remainder, whatever the signs.
  assign q_fix = div_zero ? '1    : (neg_q ? -div_q : div_q);
  assign r_fix = div_zero ? raw_a : (neg_r ? -div_r : div_r);

  // A flush in DIV releases the pipeline immediately.
  assign bus.stall = div_issue || ((state == DIV) && !div_done && !bus.flush);
  assign bus.busy  = (state == DIV);
  assign bus.we_hi = we_hi_r;
  assign bus.we_lo = we_lo_r;
  assign bus.wb_hi = wb_hi_r;
  assign bus.wb_lo = wb_lo_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      we_hi_r  <= 1'b0;
      we_lo_r  <= 1'b0;
      wb_hi_r  <= '0;
      wb_lo_r  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
    end else begin
      we_hi_r <= 1'b0;
      we_lo_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MULT: begin
                {wb_hi_r, wb_lo_r} <= prod_s;
                we_hi_r <= 1'b1;
                we_lo_r <= 1'b1;
              end
              OP_MULTU: begin
                {wb_hi_r, wb_lo_r} <= prod_u;
                we_hi_r <= 1'b1;
                we_lo_r <= 1'b1;
              end
              OP_MTHI: begin
                wb_hi_r <= bus.src_a;
                we_hi_r <= 1'b1;
              end
              OP_MTLO: begin
                wb_lo_r <= bus.src_a;
                we_lo_r <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (bus.src_b == '0);
                raw_a    <= bus.src_a;
                state    <= DIV;
              end
              default: ;
            endcase
          end
        end
        DIV: begin
          // start is ignored here; EX keeps presenting the stalled divide.
          if (bus.flush) begin
            state <= IDLE;
          end else if (div_done) begin
            wb_lo_r <= q_fix;
            wb_hi_r <= r_fix;
            we_hi_r <= 1'b1;
            we_lo_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Directed cases plus randomized ops,
// checked against an arithmetic reference model and the cycle timing of the
// HI/LO write port, stall and busy.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic f);
    bus.start = s;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.flush = f;
  endtask

  // Reference: {HI, LO} as the architecture defines it, from plain arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MTHI:  return {a, 32'd0};
      OP_MTLO:  return {32'd0, a};
      default:  return 64'd0;
    endcase
  endfunction

  // Issue one op at cycle 0 (start held while stalled), then check every
  // cycle through the write pulse and the cycle after it.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expv;
    logic        isDiv;
    expv  = refResult(o, a, b);
    isDiv = (o == OP_DIV) || (o == OP_DIVU);
    @(negedge clk);
    applyStimulus(1'b1, o, a, b, 1'b0);
    #1;
    checkOutput("issue_stall", 64'(bus.stall), 64'(isDiv));
    checkOutput("issue_busy", 64'(bus.busy), 64'd0);
    if (isDiv) begin
      for (int c = 1; c <= W; c++) begin
        @(negedge clk);
        #1;
        checkOutput("div_busy", 64'(bus.busy), 64'd1);
        checkOutput("div_stall", 64'(bus.stall), 64'(c < W));
        checkOutput("div_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("we_hi", 64'(bus.we_hi), 64'(o != OP_MTLO));
    checkOutput("we_lo", 64'(bus.we_lo), 64'(o != OP_MTHI));
    if (o != OP_MTLO) checkOutput("wb_hi", 64'(bus.wb_hi), 64'(expv[63:32]));
    if (o != OP_MTHI) checkOutput("wb_lo", 64'(bus.wb_lo), 64'(expv[31:0]));
    checkOutput("post_stall", 64'(bus.stall), 64'd0);
    checkOutput("post_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("single_pulse", 64'({bus.we_hi, bus.we_lo}), 64'd0);
    checkOutput("no_restart", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    logic [2:0] opsTab [6];
    opsTab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    rst = 1'b1;
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("reset_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
    checkOutput("reset_wb", {bus.wb_hi, bus.wb_lo}, 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_stall", 64'(bus.stall), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    runOp(OP_MULT,  32'hFFFF_FFFD, 32'd5);
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    runOp(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    runOp(OP_DIVU,  32'd100,       32'd0);
    runOp(OP_DIV,   32'hFFFF_FFF9, 32'd0);
    runOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    runOp(OP_DIV,   32'd7,         32'hFFFF_FFFE);

    // Illegal op: nothing happens
    @(negedge clk);
    applyStimulus(1'b1, 3'd7, 32'd9, 32'd9, 1'b0);
    #1;
    checkOutput("illegal_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("illegal_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
    checkOutput("illegal_busy", 64'(bus.busy), 64'd0);

    // Flush in IDLE suppresses the op
    @(negedge clk);
    applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b1);
    #1;
    checkOutput("idle_flush_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("idle_flush_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);

    // Flush a divide at cnt=10 (cycle 11)
    @(negedge clk);
    applyStimulus(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd3, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 11) applyStimulus(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd3, 1'b1);
    end
    #1;
    checkOutput("flush_stall", 64'(bus.stall), 64'd0);
    checkOutput("flush_busy_now", 64'(bus.busy), 64'd1);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("flush_busy_next", 64'(bus.busy), 64'd0);
    for (int c = 0; c < W + 2; c++) begin
      checkOutput("flush_no_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
      @(negedge clk);
      #1;
    end
    runOp(OP_MTHI, 32'h0000_1234, 32'd0);

    // Async reset at cnt=20 (cycle 21)
    @(negedge clk);
    applyStimulus(1'b1, OP_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (21) @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_we", 64'({bus.we_hi, bus.we_lo}), 64'd0);
    checkOutput("rst_mid_wb", {bus.wb_hi, bus.wb_lo}, 64'd0);
    checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_mid_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_after_busy", 64'(bus.busy), 64'd0);
    runOp(OP_MTLO, 32'hCAFE_0001, 32'd0);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      runOp(opsTab[$urandom_range(0, 5)], pickOperand(), pickOperand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage; directly upstream of the HI/LO register file.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives the HI/LO write-enable and write-data ports with registered, single-cycle write pulses.
- Multiply and move ops complete in one cycle with no stall; divide is iterative and stalls the pipeline until its final iteration.

Parameters:
WIDTH, 32, operand width; HI/LO width; number of divide iterations.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; aborts any op in flight
start  in  1  EX holds a valid MDU op this cycle
op  in  3  operation code (encodings in mdu_pkg)
src_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data
src_b  in  WIDTH  rt value: multiplier or divisor
stall  out  1  hold IF..EX; combinational
busy  out  1  divide in progress (state==DIV)
we_hi  out  1  HI write enable, one-cycle pulse
we_lo  out  1  LO write enable, one-cycle pulse
wb_hi  out  WIDTH  HI write data
wb_lo  out  WIDTH  LO write data

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, we_hi=0, we_lo=0, wb_hi=0, wb_lo=0. Reset mid-divide discards the divide.
- States are IDLE and DIV. cnt is a log2(WIDTH)-bit iteration counter.
- All we_* and wb_* outputs are registered. we_* default to 0 every cycle unless set below.
- IDLE, start=1, flush=0, sampled at the posedge:
  - MULT/MULTU: 2*WIDTH-bit product (signed or unsigned). Next cycle: {wb_hi,wb_lo}=product, we_hi=we_lo=1. No stall.
  - MTHI: next cycle wb_hi=src_a, we_hi=1, we_lo=0. MTLO: symmetric on the LO side. No stall.
  - DIV/DIVU: latch |a| and |b| (DIVU: raw values), latch the sign flags, cnt=0, go to DIV.
  - Illegal op: no action.
- DIV state: one restoring shift-subtract iteration per cycle, cnt increments.
  - At the posedge with cnt==WIDTH-1: final quotient and remainder are sign-corrected and registered.
  - Then wb_lo=quotient, wb_hi=remainder, we_hi=we_lo=1, and state returns to IDLE.
- Signed result rule: quotient is negated iff the operand signs differ; remainder takes the dividend's sign.
- 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
- Divide by zero (signed or unsigned): quotient=all ones, remainder=dividend (raw src_a). Still takes the full WIDTH iterations.
- Timing for a divide issued in cycle 0:
  - DIV occupies cycles 1..WIDTH.
  - Write pulse lands in cycle WIDTH+1.
  - stall=1 in cycles 0..WIDTH-1, 0 in cycle WIDTH.
- stall = (IDLE & start & ~flush & op∈{DIV,DIVU}) | (DIV & cnt≠WIDTH-1).
- start is ignored while in DIV, even though EX still presents the same op.
- flush=1 in DIV: next state IDLE, cnt=0, no write pulse, stall drops the same cycle.
- flush=1 in IDLE: start ignored.
- flush has priority over completion at cnt==WIDTH-1.
- busy=1 exactly while state==DIV.
- Forwarding of pending HI/LO writes is handled outside this block.

Decomposition:
- mdu_pkg:
  - op encodings OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6 (0 = none)
  - state enum {IDLE, DIV}
- Sub-module div_core: the iterative restoring divider with start/abort/done and unsigned datapath.
- Sign handling, multiply, the FSM and the output registers stay in mdu.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=5 -> next cycle we_hi=we_lo=1, wb_hi=0xFFFFFFFF, wb_lo=0xFFFFFFF1; stall never high.
- MULTU a=0xFFFFFFFF, b=2 -> wb_hi=0x00000001, wb_lo=0xFFFFFFFE.
- DIV a=-7, b=2 issued cycle 0, start held while stalled -> stall high cycles 0..31, low at 32; cycle 33 wb_lo=0xFFFFFFFD, wb_hi=0xFFFFFFFF, single pulse; no restart.
- DIVU a=100, b=0 -> after 32 iterations wb_lo=0xFFFFFFFF, wb_hi=0x00000064.
- DIV in flight, flush at cnt=10 -> no we pulse, stall low same cycle, busy low next; then MTHI 0x1234 -> next cycle we_hi=1, wb_hi=0x00001234, we_lo=0.
- rst asserted mid-divide (cnt=20) -> all outputs 0 immediately, state IDLE; a following MTLO works normally.
